lif_pe: RTL

- Parametrised leaky integrate-and-fire processing element. Successor to the single-weight accumulate PE.
- Holds NUM_SYN signed synaptic weights. Accepts one timestep of input spikes per handshake and accumulates the weights of active synapses serially, one synapse per cycle.
- Applies leak, compares against a programmable threshold, emits an output spike, then enforces a refractory period.
- Instantiated per neuron inside the SNN core array; driven by the layer scheduler.

---
 rtl/lif_pe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lif_pe.sv
`default_nettype none
// ============================================================================
// Module   : lif_pe
// Brief    : Leaky integrate-and-fire neuron PE. It accumulates one synapse
//            per cycle, then does leak, a threshold check and the refractory
//            period. The LIF_PE_LEAK_EN macro turns on the leak in FIRE.
// Revision : 1.0 - initial release
// ============================================================================
module lif_pe #(
    parameter  int NUM_SYN       = 4,
    parameter  int WEIGHT_W      = 8,
    parameter  int POT_W         = 16,
    parameter  int LEAK_SHIFT    = 3,
    parameter  int REFRAC_CYCLES = 2,
    localparam int C_ADDR_W      = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       weight_w_en,
    input  logic [C_ADDR_W-1:0]        weight_addr,
    input  logic signed [WEIGHT_W-1:0] weight_in,
    input  logic signed [POT_W-1:0]    threshold,
    input  logic                       step_valid,
    output logic                       step_ready,
    input  logic [NUM_SYN-1:0]         spike_in,
    output logic                       spike,
    output logic                       spike_done,
    output logic signed [POT_W-1:0]    memb_pot
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_FIRE  = 2'd2;

    localparam int c_REF_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
    localparam logic signed [POT_W-1:0] c_POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
    localparam logic signed [POT_W-1:0] c_POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

`ifdef LIF_PE_LEAK_EN
    localparam bit c_LEAK_EN = 1'b1;
`else
    localparam bit c_LEAK_EN = 1'b0;
`endif

    logic [1:0]                 r_state;
    logic [1:0]                 w_next_state;
    logic signed [WEIGHT_W-1:0] r_weight [NUM_SYN];
    logic [NUM_SYN-1:0]         r_spikes;
    logic [C_ADDR_W-1:0]        r_idx;
    logic signed [POT_W-1:0]    r_pot;
    logic [c_REF_W-1:0]         r_refrac;
    logic                       r_spike;
    logic                       r_done;

    logic                       w_accum_en;
    logic                       w_fire_en;
    logic                       w_idx_last;
    logic signed [WEIGHT_W-1:0] w_weight;
    logic [POT_W:0]             w_sum;
    logic signed [POT_W-1:0]    w_sat;
    logic signed [POT_W-1:0]    w_leaked;

    // Out-of-range addresses match no slot and are dropped.
    generate
        for (genvar i = 0; i < NUM_SYN; i++) begin : g_weight
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_weight[i] <= '0;
                end else if (weight_w_en && (weight_addr == C_ADDR_W'(i))) begin
                    r_weight[i] <= weight_in;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (step_valid) w_next_state = c_ACCUM;
            c_ACCUM: if (w_idx_last) w_next_state = c_FIRE;
            c_FIRE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        step_ready = (r_state == c_IDLE);
        w_accum_en = (r_state == c_ACCUM);
        w_fire_en  = (r_state == c_FIRE);
    end

    assign w_idx_last = (r_idx == C_ADDR_W'(NUM_SYN - 1));
    assign w_weight   = r_weight[r_idx];

    // One guard bit catches overflow; clamp instead of wrapping.
    assign w_sum = {r_pot[POT_W-1], r_pot}
                 + {{(POT_W + 1 - WEIGHT_W){w_weight[WEIGHT_W-1]}}, w_weight};
    assign w_sat = (w_sum[POT_W] != w_sum[POT_W-1])
                 ? (w_sum[POT_W] ? c_POT_MIN : c_POT_MAX)
                 : w_sum[POT_W-1:0];

    assign w_leaked = c_LEAK_EN ? (r_pot - (r_pot >>> LEAK_SHIFT)) : r_pot;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_spikes <= '0;
            r_idx    <= '0;
            r_pot    <= '0;
            r_refrac <= '0;
            r_spike  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_spike <= 1'b0;
            r_done  <= 1'b0;
            if (step_ready && step_valid) begin
                r_spikes <= spike_in;
                r_idx    <= '0;
            end
            if (w_accum_en) begin
                r_idx <= r_idx + 1'b1;
                if (r_spikes[r_idx] && (r_refrac == '0)) begin
                    r_pot <= w_sat;
                end
            end
            if (w_fire_en) begin
                r_done <= 1'b1;
                if ((r_refrac == '0) && (w_leaked >= threshold)) begin
                    r_spike  <= 1'b1;
                    r_pot    <= '0;
                    r_refrac <= c_REF_W'(REFRAC_CYCLES);
                end else begin
                    r_pot <= w_leaked;
                    if (r_refrac != '0) begin
                        r_refrac <= r_refrac - 1'b1;
                    end
                end
            end
        end
    end

    assign spike      = r_spike;
    assign spike_done = r_done;
    assign memb_pot   = r_pot;

endmodule
`default_nettype wire
